// File: rtl/byte_port_arbiter_if.sv
// Bundle of requester-side and sink-side signals around the shared byte port.
// The arbiter uses the slave modport; the environment drives through master.
interface byte_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           port_a;
  logic                 port_a_valid;
  logic                 port_b;
  logic [IdW-1:0]       grant_id;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, port_b,
    input  req_ready, port_a, port_a_valid, grant_id, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, port_b,
    output req_ready, port_a, port_a_valid, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/byte_port_arbiter.sv
// Round-robin arbiter sharing one byte port between NUM_REQ requesters,
// one byte in flight, with a bounded wait for the sink's ack.
module byte_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_port_arbiter_if.slave   bus
);
  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("byte_port_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StWait, StRecover} state_e;

  state_e             state_q;
  logic [IdW-1:0]     ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic [7:0]         port_a_q;
  logic               valid_q;
  logic [IdW-1:0]     grant_id_q;
  logic               timeout_err_q;

  logic               grant_any;
  logic [IdW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant_oh;

  // Scan starts one past the last accepted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IdW'(idx);
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign bus.req_ready    = (rst && state_q == StIdle) ? grant_oh : '0;
  assign bus.port_a       = port_a_q;
  assign bus.port_a_valid = valid_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.timeout_err  = timeout_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      ptr_q         <= IdW'(NUM_REQ - 1);
      cnt_q         <= '0;
      port_a_q      <= '0;
      valid_q       <= 1'b0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            port_a_q   <= bus.req_data[{grant_idx, 3'b000} +: 8];
            valid_q    <= 1'b1;
            grant_id_q <= grant_idx;
            ptr_q      <= grant_idx;
            cnt_q      <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          // Ack takes precedence over an expiring count.
          if (bus.port_b) begin
            valid_q <= 1'b0;
            state_q <= StRecover;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            valid_q       <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRecover: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_port_arbiter.sv
// Bench for byte_port_arbiter: directed table, corner sequences and random
// traffic checked every cycle against a transaction-level model.
module tb_byte_port_arbiter;
  localparam int N = 4;
  localparam int T = 50;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  byte_port_arbiter_if #(.NUM_REQ(N)) bus ();

  byte_port_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one byte in flight with an age, a one-cycle cooldown after an ack.
  bit        m_inflight;
  bit        m_cool;
  int        m_age;
  int        m_last;
  logic [7:0] m_byte;
  int        m_gid;
  bit        m_terr;
  int        m_acc;

  typedef struct {
    logic [3:0] valid;
    int         ack_delay;
    int         exp_gid;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_inflight = 0;
    m_cool     = 0;
    m_age      = 0;
    m_last     = N - 1;
    m_byte     = 8'h00;
    m_gid      = 0;
    m_terr     = 0;
    m_acc      = -1;
  endfunction

  function automatic int model_pick();
    if (!rst || m_inflight || m_cool) return -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_edge();
    int pick;
    if (!rst) begin
      model_reset();
      return;
    end
    pick   = model_pick();
    m_terr = 0;
    m_acc  = -1;
    if (m_inflight) begin
      if (bus.port_b) begin
        m_inflight = 0;
        m_cool     = 1;
      end else if (m_age == T - 1) begin
        m_inflight = 0;
        m_terr     = 1;
      end else begin
        m_age++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (pick >= 0) begin
      m_inflight = 1;
      m_age      = 0;
      m_byte     = bus.req_data[8*pick +: 8];
      m_gid      = pick;
      m_last     = pick;
      m_acc      = pick;
    end
  endfunction

  task automatic check_all();
    int pick;
    logic [31:0] exp_ready;
    pick      = model_pick();
    exp_ready = (pick < 0) ? 32'd0 : (32'd1 << pick);
    check("req_ready", 32'(bus.req_ready), exp_ready);
    check("port_a", 32'(bus.port_a), 32'(m_byte));
    check("port_a_valid", 32'(bus.port_a_valid), 32'(m_inflight));
    check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check("busy", 32'(bus.busy), 32'(m_inflight | m_cool));
    check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    bus.port_b    = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic [7:0] rdy_seq;
    logic [7:0] val_seq;
    int vcnt;
    int tcnt;
    bit got;

    tbl[0] = '{4'hF,    1, 0, 8'h10};
    tbl[1] = '{4'hF,    1, 1, 8'h11};
    tbl[2] = '{4'hF,    1, 2, 8'h12};
    tbl[3] = '{4'hF,    1, 3, 8'h13};
    tbl[4] = '{4'hF,    1, 0, 8'h10};
    tbl[5] = '{4'b1000, 0, 3, 8'h13};
    tbl[6] = '{4'b0101, 2, 0, 8'h10};
    tbl[7] = '{4'b0101, 3, 2, 8'h12};
    tbl[8] = '{4'b0011, 0, 0, 8'h10};
    tbl[9] = '{4'b0010, 2, 1, 8'h11};

    // Reset with every requester asserting.
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.port_b    = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_port_a", 32'(bus.port_a), 32'd0);
    check("rst_valid", 32'(bus.port_a_valid), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table: grant order and captured byte.
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = tbl[i].valid;
      bus.port_b    = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (m_acc >= 0) got = 1;
      end
      check("tbl_accepted", 32'(got), 32'd1);
      check("tbl_grant_id", 32'(bus.grant_id), 32'(tbl[i].exp_gid));
      check("tbl_port_a", 32'(bus.port_a), 32'(tbl[i].exp_byte));
      bus.req_valid = '0;
      repeat (tbl[i].ack_delay) tick();
      bus.port_b = 1'b1;
      tick();
      bus.port_b = 1'b0;
    end
    idle(2);

    // Single requester, ack three cycles after accept, re-accept at ack edge + 2.
    bus.req_valid       = 4'b0001;
    bus.req_data[7:0]   = 8'hA5;
    rdy_seq = '0;
    val_seq = '0;
    for (int c = 0; c < 8; c++) begin
      bus.port_b = (c == 3);
      #1;
      rdy_seq[c] = bus.req_ready[0];
      val_seq[c] = bus.port_a_valid;
      if (c == 1) check("a5_port_a", 32'(bus.port_a), 32'hA5);
      tick();
    end
    check("a5_ready_seq", 32'(rdy_seq), 32'h21);
    check("a5_valid_seq", 32'(val_seq), 32'hCE);
    bus.req_valid = '0;
    bus.port_b    = 1'b1;
    tick();
    idle(2);

    // No ack: valid for exactly TIMEOUT cycles, one error pulse, no cooldown.
    bus.req_valid = 4'b0001;
    tick();
    check("to_accepted", 32'(m_acc), 32'd0);
    bus.req_valid = '0;
    vcnt = 0;
    tcnt = 0;
    for (int c = 0; c < T + 5; c++) begin
      if (bus.port_a_valid) vcnt++;
      if (bus.timeout_err) begin
        tcnt++;
        check("to_valid_drop", 32'(bus.port_a_valid), 32'd0);
        check("to_busy_drop", 32'(bus.busy), 32'd0);
      end
      tick();
    end
    check("to_valid_cycles", 32'(vcnt), 32'(T));
    check("to_pulses", 32'(tcnt), 32'd1);

    // Ack on the last possible cycle beats the timeout.
    bus.req_valid = 4'b0001;
    tick();
    check("edge_accepted", 32'(m_acc), 32'd0);
    bus.req_valid = '0;
    repeat (T - 1) tick();
    bus.port_b = 1'b1;
    tick();
    bus.port_b = 1'b0;
    check("edge_no_timeout", 32'(bus.timeout_err), 32'd0);
    check("edge_recover_busy", 32'(bus.busy), 32'd1);
    check("edge_valid", 32'(bus.port_a_valid), 32'd0);
    tick();
    check("edge_idle", 32'(bus.busy), 32'd0);

    // Async reset while requester 2 waits; pointer returns to top priority for 0.
    bus.req_valid = 4'b0100;
    tick();
    check("rw_grant2", 32'(bus.grant_id), 32'd2);
    bus.req_valid = 4'b0110;
    #2 rst = 1'b0;
    #1;
    check("rw_valid_async", 32'(bus.port_a_valid), 32'd0);
    check("rw_busy_async", 32'(bus.busy), 32'd0);
    check("rw_ready_async", 32'(bus.req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rw_grant1", 32'(bus.grant_id), 32'd1);
    bus.port_b = 1'b1;
    tick();
    idle(2);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (m_acc >= 0) begin
        bus.req_valid[m_acc]         = 1'($urandom % 2);
        bus.req_data[8*m_acc +: 8]   = 8'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && ($urandom % 4 == 0)) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = 8'($urandom);
        end
      end
      bus.port_b = ($urandom % 4 == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
